// File: rtl/square_wave_pkg.sv
// Shared definitions for the square-wave period/high-time monitor.
package square_wave_pkg;

  localparam int          CNT_W_DEF         = 16;
  localparam int unsigned TIMEOUT_TICKS_DEF = 32'd50000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } sw_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, followed by rise/fall detection.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic level
);

  logic sync_p0;
  logic sync_p1;
  logic s_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      s_prev  <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      s_prev  <= sync_p1;
    end
  end

  // Edge stage: s_prev lags the synchronized level by one cycle
  assign level = sync_p1;
  assign rise  = sync_p1 & ~s_prev;
  assign fall  = ~sync_p1 & s_prev;

endmodule

// File: rtl/square_wave_monitor.sv
// Measures period and high time of an asynchronous square wave in clk cycles,
// flags lock on two equal consecutive periods and timeout when edges stop.
module square_wave_monitor
  import square_wave_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int          CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             square_wave,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             lock,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_TICKS);

  logic             rise;
  logic             fall;
  logic             s_sync;
  logic             unused_level;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_pend;
  logic             measure;
  logic             tmo_hit;
  sw_state_e        state;
  sw_state_e        state_nxt;

  sync_edge_detect u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .d     (square_wave),
    .rise  (rise),
    .fall  (fall),
    .level (s_sync)
  );

  // Only the edges drive the measurement; the synchronized level is not needed here.
  assign unused_level = s_sync;

  // A rise outranks a coincident timeout, so tmo_hit excludes it.
  assign measure = rise && (state != IDLE);
  assign tmo_hit = (state != IDLE) && !rise && (cnt == TIMEOUT_VAL);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rise) state_nxt = HIGH;
      HIGH: begin
        if (rise)         state_nxt = HIGH;
        else if (tmo_hit) state_nxt = IDLE;
        else if (fall)    state_nxt = LOW;
      end
      LOW: begin
        if (rise)         state_nxt = HIGH;
        else if (tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      high_pend  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      lock       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= measure;

      if (rise)                cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      if ((state == HIGH) && fall) high_pend <= cnt;

      // A rise while still HIGH means the fall was never seen: the whole period was high.
      if (measure) begin
        period    <= cnt;
        high_time <= (state == HIGH) ? cnt : high_pend;
        lock      <= (cnt == period);
      end else if (tmo_hit) begin
        lock      <= 1'b0;
      end

      if (rise)         timeout <= 1'b0;
      else if (tmo_hit) timeout <= 1'b1;
    end
  end

endmodule
